fp_multiplier_seq: RTL
======================

Name: fp_multiplier_seq

Overview:
Parametrised IEEE-754-style floating-point multiplier built as an iterative, multi-cycle unit with valid/ready handshakes on input and output. Successor to the combinational single-precision multiplier. Adds:
- generic exponent/mantissa widths
- special-operand handling, round-to-nearest-even, overflow/underflow saturation
- a shift-add mantissa datapath that trades latency for area

Sits between the operand register file and the FPU result writeback path.

Parameters:
EXP_W, 8, exponent field width
MAN_W, 23, stored fraction width (hidden bit excluded); DATA_W = 1+EXP_W+MAN_W derived

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  reset, asynchronous, active-high
valid_i  input  1  operands present
ready_o  output  1  unit can accept operands
dataA_i  input  DATA_W  operand A
dataB_i  input  DATA_W  operand B
valid_o  output  1  result present
ready_i  input  1  consumer accepts result
data_o  output  DATA_W  product

Behaviour:
- Reset:
  - Async on rst_i high: state=IDLE; ready_o=1, valid_o=0, data_o=0; counter and accumulator cleared.
  - Reset mid-operation discards the in-flight product; no output is produced for it.
- Handshake:
  - Operands are captured on the edge where valid_i&&ready_o.
  - ready_o=1 only in IDLE.
  - Result is held stable in DONE while valid_o=1 until valid_o&&ready_i; then return to IDLE with ready_o=1 on the next cycle. No back-to-back overlap.
- Unpack at capture:
  - sign = sA^sB.
  - Zero = exp 0 (fraction ignored; subnormals flushed to zero).
  - Inf = exp all-ones, frac 0. NaN = exp all-ones, frac≠0.
- FSM states IDLE, MUL, ROUND, DONE:
  - IDLE->DONE at capture if either operand is special.
    - NaN or Inf×0: result = canonical qNaN (sign 0, exp all-ones, frac MSB 1, rest 0).
    - Inf×nonzero: signed Inf. Zero×finite: signed zero.
    - Latency: valid_o high 1 cycle after capture.
  - IDLE->MUL otherwise. Counter cnt=0; accumulator P (2*(MAN_W+1) bits)=0; mantissas get the hidden 1.
  - MUL: one multiplier bit per cycle (LSB first, add-shift). cnt increments; after MAN_W+1 iterations go to ROUND.
  - ROUND, one cycle:
    - Normalise: if P MSB=1, take fraction from the upper bits and exp+1.
    - Guard bit, sticky = OR of remaining bits; round-to-nearest-even.
    - Mantissa carry-out on rounding renormalises and exp+1.
    - Go to DONE.
- Normal-path latency: valid_o high MAN_W+3 cycles after the capture edge (26 for defaults).
- Exponent arithmetic:
  - Computed signed in EXP_W+2 bits: e = eA+eB-BIAS+norm+roundcarry, BIAS = 2^(EXP_W-1)-1.
  - e >= 2^EXP_W-1 -> signed Inf.
  - e <= 0 -> signed zero (flush, no subnormal output).
- valid_i while busy is ignored; the source must hold it since ready_o=0.

Optional Feature:
Macro FPMUL_EXC_FLAGS_EN.
- Defined: adds output flags_o[3:0] = {invalid, overflow, underflow, inexact}.
  - Registered alongside data_o and valid in DONE.
  - Reset 0; cleared on the IDLE capture edge.
  - invalid = NaN operand or Inf×0.
  - overflow = saturated to Inf from the finite path.
  - underflow = flushed to zero from the nonzero finite path.
  - inexact = guard|sticky, or overflow/underflow.
- Undefined: no port, no flag logic. Data behaviour is identical either way.

Decomposition:
- Package fpmul_pkg holds:
  - state enum (IDLE/MUL/ROUND/DONE)
  - bias function of EXP_W
  - qNaN/Inf/zero constant builders
  - flag bit indices
- One sub-module, fp_round_rne: combinational normalise + RNE + exponent saturation, feeding the ROUND state.

Test Plan:
- A=0x3FC00000 (1.5), B=0x40000000 (2.0), ready_i=1 -> data_o=0x40400000; valid_o exactly 26 cycles after capture.
- A=0x3F800001, B=0x3F800001 -> 0x3F800002 (RNE, inexact flag when enabled); A=0xBF800000, B=0x3F800000 -> 0xBF800000.
- Specials:
  - 0x7F800000 × 0x00000000 -> 0x7FC00000 (invalid flag when enabled).
  - 0xFF800000 × 0x40000000 -> 0xFF800000.
  - 0x7FC00000 × anything -> 0x7FC00000.
  - Each with 1-cycle latency.
- 0x7F000000×0x7F000000 -> 0x7F800000 (overflow); 0x00800000×0x00800000 -> 0x00000000 (underflow); 0x80800000×0x00800000 -> 0x80000000.
- Backpressure: hold ready_i=0 for 10 cycles after valid_o -> data_o/valid_o stable and ready_o=0 throughout; ready_i=1 -> ready_o=1 next cycle, next operand accepted.
- Assert rst_i asynchronously mid-MUL (cnt=10) -> valid_o=0, ready_o=1 immediately; the next op 0x40400000×0x3F000000 returns 0x3FC00000.

Source files
------------

// File: rtl/fpmul_pkg.sv
// Shared types and constant builders for the sequential FP multiplier.
// Pure declarations; no timing or flow-control behaviour of its own.
// Consumers import it; nothing here holds state.
package fpmul_pkg;

    typedef enum logic [1:0] {IDLE, MUL, ROUND, DONE} state_t;

    localparam int FLG_INVALID   = 3;
    localparam int FLG_OVERFLOW  = 2;
    localparam int FLG_UNDERFLOW = 1;
    localparam int FLG_INEXACT   = 0;

    function automatic int bias_of(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    // Builders return 64-bit images; callers truncate to their DATA_W.
    function automatic logic [63:0] inf_bits(input int exp_w, input int man_w, input logic s);
        return (((64'd1 << exp_w) - 64'd1) << man_w) | ({63'd0, s} << (exp_w + man_w));
    endfunction

    function automatic logic [63:0] qnan_bits(input int exp_w, input int man_w);
        return inf_bits(exp_w, man_w, 1'b0) | (64'd1 << (man_w - 1));
    endfunction

    function automatic logic [63:0] zero_bits(input int exp_w, input int man_w, input logic s);
        return {63'd0, s} << (exp_w + man_w);
    endfunction

endpackage

// File: rtl/fp_round_rne.sv
// Normalise + round-to-nearest-even + exponent saturation of a raw mantissa product.
// Purely combinational (zero latency); no flow control, the caller samples it in ROUND.
// Exception outputs exist only when FPMUL_EXC_FLAGS_EN is defined.
module fp_round_rne
    import fpmul_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic [2*MAN_W+1:0]       p_i,
    input  logic signed [EXP_W+1:0]  exp_i,
    input  logic                     sign_i,
    output logic [EXP_W+MAN_W:0]     res_o
`ifdef FPMUL_EXC_FLAGS_EN
    ,
    output logic                     ovf_o,
    output logic                     unf_o,
    output logic                     inx_o
`endif
);
    localparam int M  = MAN_W + 1;
    localparam int PW = 2 * M;
    localparam int EW = EXP_W + 2;
    localparam int DW = 1 + EXP_W + MAN_W;
    localparam logic signed [EW-1:0] EMAX = EW'((2 ** EXP_W) - 1);

    logic                 norm;
    logic [PW-2:0]        sh;
    logic [MAN_W-1:0]     frac;
    logic                 guard;
    logic                 sticky;
    logic                 rnd_up;
    logic [MAN_W:0]       frac_r;
    logic signed [EW-1:0] e;
    logic                 ovf;
    logic                 unf;

    always_comb begin
        // Product lies in [1,4): the top bit selects which window holds the fraction.
        norm   = p_i[PW-1];
        sh     = norm ? p_i[PW-2:0] : {p_i[PW-3:0], 1'b0};
        frac   = sh[PW-2:M];
        guard  = sh[M-1];
        sticky = |sh[M-2:0];
        rnd_up = guard & (sticky | frac[0]);
        frac_r = {1'b0, frac} + {{MAN_W{1'b0}}, rnd_up};
        e      = exp_i + EW'(norm) + EW'(frac_r[MAN_W]);
        ovf    = (e >= EMAX);
        unf    = e[EW-1] | (e == '0);
        res_o  = {sign_i, e[EXP_W-1:0], frac_r[MAN_W-1:0]};
        if (ovf) begin
            res_o = DW'(inf_bits(EXP_W, MAN_W, sign_i));
        end else if (unf) begin
            res_o = DW'(zero_bits(EXP_W, MAN_W, sign_i));
        end
    end

`ifdef FPMUL_EXC_FLAGS_EN
    assign ovf_o = ovf;
    assign unf_o = unf;
    assign inx_o = guard | sticky | ovf | unf;
`endif

endmodule

// File: rtl/fp_multiplier_seq.sv
// Iterative IEEE-style multiplier (shift-add, one multiplier bit per cycle); optional flags via FPMUL_EXC_FLAGS_EN.
// Latency: MAN_W+3 cycles on the normal path, 1 cycle for special operands.
// Accepts one op at a time (ready_o only in IDLE); result held in DONE until ready_i.
module fp_multiplier_seq
    import fpmul_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     valid_i,
    output logic                     ready_o,
    input  logic [EXP_W+MAN_W:0]     dataA_i,
    input  logic [EXP_W+MAN_W:0]     dataB_i,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic [EXP_W+MAN_W:0]     data_o
`ifdef FPMUL_EXC_FLAGS_EN
    ,
    output logic [3:0]               flags_o
`endif
);
    localparam int M  = MAN_W + 1;
    localparam int PW = 2 * M;
    localparam int EW = EXP_W + 2;
    localparam int DW = 1 + EXP_W + MAN_W;
    localparam int CW = $clog2(M + 1);
    localparam int BIAS = bias_of(EXP_W);

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [PW-1:0]        p_q, p_d;
    logic [M-1:0]         ma_q, ma_d, mb_q, mb_d;
    logic                 sign_q, sign_d;
    logic signed [EW-1:0] exp_q, exp_d;
    logic [DW-1:0]        data_q, data_d;
    logic [DW-1:0]        rnd_res;
    logic [M:0]           acc_sum;

    logic                 sa, sb;
    logic [EXP_W-1:0]     ea, eb;
    logic [MAN_W-1:0]     fa, fb;
    logic                 a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic signed [EW-1:0] e_pre;

`ifdef FPMUL_EXC_FLAGS_EN
    logic [3:0] flags_q, flags_d;
    logic       ovf, unf, inx;
`endif

    assign sa = dataA_i[DW-1];
    assign sb = dataB_i[DW-1];
    assign ea = dataA_i[DW-2:MAN_W];
    assign eb = dataB_i[DW-2:MAN_W];
    assign fa = dataA_i[MAN_W-1:0];
    assign fb = dataB_i[MAN_W-1:0];
    assign a_zero = (ea == '0);
    assign b_zero = (eb == '0);
    assign a_inf  = (&ea) && (fa == '0);
    assign b_inf  = (&eb) && (fb == '0);
    assign a_nan  = (&ea) && (fa != '0);
    assign b_nan  = (&eb) && (fb != '0);
    assign e_pre  = EW'({2'b00, ea}) + EW'({2'b00, eb}) - EW'(BIAS);

    fp_round_rne #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_round (
        .p_i    (p_q),
        .exp_i  (exp_q),
        .sign_i (sign_q),
        .res_o  (rnd_res)
`ifdef FPMUL_EXC_FLAGS_EN
        ,
        .ovf_o  (ovf),
        .unf_o  (unf),
        .inx_o  (inx)
`endif
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        ma_d    = ma_q;
        mb_d    = mb_q;
        sign_d  = sign_q;
        exp_d   = exp_q;
        data_d  = data_q;
`ifdef FPMUL_EXC_FLAGS_EN
        flags_d = flags_q;
`endif
        acc_sum = {1'b0, p_q[PW-1:M]} + (mb_q[0] ? {1'b0, ma_q} : '0);
        case (state_q)
            IDLE: if (valid_i) begin
                sign_d = sa ^ sb;
`ifdef FPMUL_EXC_FLAGS_EN
                flags_d = '0;
`endif
                if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
                    data_d  = DW'(qnan_bits(EXP_W, MAN_W));
                    state_d = DONE;
`ifdef FPMUL_EXC_FLAGS_EN
                    flags_d[FLG_INVALID] = 1'b1;
`endif
                end else if (a_inf || b_inf) begin
                    data_d  = DW'(inf_bits(EXP_W, MAN_W, sa ^ sb));
                    state_d = DONE;
                end else if (a_zero || b_zero) begin
                    data_d  = DW'(zero_bits(EXP_W, MAN_W, sa ^ sb));
                    state_d = DONE;
                end else begin
                    cnt_d   = '0;
                    p_d     = '0;
                    ma_d    = {1'b1, fa};
                    mb_d    = {1'b1, fb};
                    exp_d   = e_pre;
                    state_d = MUL;
                end
            end
            MUL: begin
                // Add-shift: low product bits retire out of the bottom of P.
                p_d   = {acc_sum, p_q[M-1:1]};
                mb_d  = mb_q >> 1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(M - 1)) state_d = ROUND;
            end
            ROUND: begin
                data_d  = rnd_res;
                state_d = DONE;
`ifdef FPMUL_EXC_FLAGS_EN
                flags_d = {1'b0, ovf, unf, inx};
`endif
            end
            DONE: if (ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            p_q     <= '0;
            ma_q    <= '0;
            mb_q    <= '0;
            sign_q  <= 1'b0;
            exp_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
            ma_q    <= ma_d;
            mb_q    <= mb_d;
            sign_q  <= sign_d;
            exp_q   <= exp_d;
            data_q  <= data_d;
        end
    end

`ifdef FPMUL_EXC_FLAGS_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) flags_q <= '0;
        else       flags_q <= flags_d;
    end
    assign flags_o = flags_q;
`endif

    assign ready_o = (state_q == IDLE);
    assign valid_o = (state_q == DONE);
    assign data_o  = data_q;

endmodule
